// File: rtl/sigma_delta_dac_mc_pkg.sv
// Shared definitions for the multi-channel sigma-delta DAC: order encoding,
// integrator width offsets and the saturating clamp used by the second-order loop.
package sigma_delta_dac_mc_pkg;

   typedef enum logic {
      ORDER1 = 1'b0,
      ORDER2 = 1'b1
   } order_e;

   // Integrator widths relative to the sample width: i1 is WIDTH+3, i2 is WIDTH+5.
   localparam int I1_EXTRA = 3;
   localparam int I2_EXTRA = 5;

   localparam int WIDE_W = 64;
   typedef logic signed [WIDE_W-1:0] wide_t;

   function automatic wide_t sat(input wide_t x, input int w);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo = -hi - wide_t'(1);
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/sd_mod_channel.sv
// One DAC channel: input latch, soft-mute ramp of the working value, and a
// first- or second-order modulator producing a registered 1-bit output.
module sd_mod_channel
   import sigma_delta_dac_mc_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int SIGNED_IN = 1,
   parameter int RAMP_STEP = 256
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ce,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  order_e           order_q,
   input  logic             order_chg,
   input  logic             mute,
   input  logic             mute_chg,
   output logic             at_mid,
   output logic             dac_out
);

   localparam int I1_W = WIDTH + I1_EXTRA;
   localparam int I2_W = WIDTH + I2_EXTRA;
   localparam logic [WIDTH-1:0] MID    = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] STEP_N = WIDTH'(RAMP_STEP);
   localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(RAMP_STEP);

   logic [WIDTH-1:0]       latch_q, latch_d;
   logic [WIDTH-1:0]       cur_q, cur_d;
   logic [WIDTH-1:0]       acc_q, acc_d;
   logic signed [I1_W-1:0] i1_q, i1_d, i1_next;
   logic signed [I2_W-1:0] i2_q, i2_d, i2_next;
   logic                   ramp_q, ramp_d;
   logic                   dac_q, dac_d;
   logic [WIDTH-1:0]       in_u, target;
   logic [WIDTH:0]         acc_sum;
   logic                   ramp_now;
   wide_t                  v, fb;

   // NOTE: every _d takes its hold value first, so no path through this block infers a latch.
   always_comb begin
      latch_d = latch_q;
      cur_d   = cur_q;
      acc_d   = acc_q;
      i1_d    = i1_q;
      i2_d    = i2_q;
      ramp_d  = ramp_q;
      dac_d   = dac_q;

      in_u     = (SIGNED_IN != 0) ? (in_data ^ MID) : in_data;
      target   = mute ? MID : latch_q;
      ramp_now = ramp_q | mute_chg;
      acc_sum  = {1'b0, acc_q} + {1'b0, cur_q};
      v        = wide_t'(cur_q) - wide_t'(MID);
      fb       = dac_q ? wide_t'(MID) : -wide_t'(MID);
      i1_next  = I1_W'(sat(wide_t'(i1_q) + v - fb, I1_W));
      i2_next  = I2_W'(sat(wide_t'(i2_q) + wide_t'(i1_next) - fb, I2_W));

      if (in_valid) latch_d = in_u;

      if (ce) begin
         if (!ramp_now) begin
            cur_d = latch_q;
         end else begin
            if (cur_q < target)
               cur_d = (({1'b0, target} - {1'b0, cur_q}) <= STEP_W) ? target : cur_q + STEP_N;
            else if (cur_q > target)
               cur_d = (({1'b0, cur_q} - {1'b0, target}) <= STEP_W) ? target : cur_q - STEP_N;
            // Unmuted ramps end once target is reached; muted channels stay parked in RAMP.
            ramp_d = mute || (cur_d != target);
         end

         if (order_chg) begin
            acc_d = '0;
            i1_d  = '0;
            i2_d  = '0;
         end else if (order_q == ORDER1) begin
            acc_d = acc_sum[WIDTH-1:0];
            dac_d = acc_sum[WIDTH];
         end else begin
            i1_d  = i1_next;
            i2_d  = i2_next;
            dac_d = ~i2_next[I2_W-1];
         end
      end
   end

   // NOTE: state flops use non-blocking assignment only, and every one of them, the input latch included, gets a reset value.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         latch_q <= MID;
         cur_q   <= MID;
         acc_q   <= '0;
         i1_q    <= '0;
         i2_q    <= '0;
         ramp_q  <= 1'b1;
         dac_q   <= 1'b0;
      end else begin
         latch_q <= latch_d;
         cur_q   <= cur_d;
         acc_q   <= acc_d;
         i1_q    <= i1_d;
         i2_q    <= i2_d;
         ramp_q  <= ramp_d;
         dac_q   <= dac_d;
      end
   end

   assign at_mid  = (cur_q == MID);
   assign dac_out = dac_q;

endmodule

// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel sigma-delta DAC top: shared order/mute tracking, per-channel
// modulators, and the registered all-channels-muted flag.
module sigma_delta_dac_mc
   import sigma_delta_dac_mc_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int CHANNELS  = 2,
   parameter int SIGNED_IN = 1,
   parameter int RAMP_STEP = 256
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      ce,
   input  logic                      in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic                      order_sel,
   input  logic                      mute,
   output logic                      muted,
   output logic [CHANNELS-1:0]       DACout
);

   order_e              order_q, order_d;
   logic                mute_q, mute_d;
   logic                muted_q, muted_d;
   logic                order_chg, mute_chg;
   logic [CHANNELS-1:0] at_mid;

   always_comb begin
      order_chg = ce && (order_e'(order_sel) != order_q);
      mute_chg  = ce && (mute != mute_q);
      order_d   = ce ? order_e'(order_sel) : order_q;
      mute_d    = ce ? mute : mute_q;
      muted_d   = mute && (&at_mid);
   end

   // muted runs every clock; order and mute tracking advance only on ce ticks.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         order_q <= ORDER1;
         mute_q  <= 1'b0;
         muted_q <= 1'b0;
      end else begin
         order_q <= order_d;
         mute_q  <= mute_d;
         muted_q <= muted_d;
      end
   end

   assign muted = muted_q;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      sd_mod_channel #(
         .WIDTH     (WIDTH),
         .SIGNED_IN (SIGNED_IN),
         .RAMP_STEP (RAMP_STEP)
      ) u_ch (
         .CLK       (CLK),
         .RESET     (RESET),
         .ce        (ce),
         .in_valid  (in_valid),
         .in_data   (in_data[k*WIDTH +: WIDTH]),
         .order_q   (order_q),
         .order_chg (order_chg),
         .mute      (mute),
         .mute_chg  (mute_chg),
         .at_mid    (at_mid[k]),
         .dac_out   (DACout[k])
      );
   end

endmodule
